fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 185 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with PC, 2-entry fetch queue and epoch squashing.
// Optional 2-bit BHT branch predictor enabled by defining FETCH_BHT_EN.
module fetch_stage #(
    parameter int         PC_W       = 8,
    parameter int         INSTR_W    = 16,
    parameter int         BHT_IDX    = 4,
    parameter logic [3:0] BR_OPCODE  = 4'hC,
    parameter logic [3:0] JMP_OPCODE = 4'hD
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               flush,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    input  logic               update,
    input  logic [PC_W-1:0]    update_pc,
    input  logic               update_taken,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [INSTR_W-1:0] instruction_IF,
    output logic [PC_W-1:0]    pc_IF,
    output logic               valid_IF,
    output logic               predict_taken
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic               pred;
    } fq_t;

    fq_t             q0;
    fq_t             q1;
    fq_t             incoming;
    logic [1:0]      count;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic            epoch;
    logic            inflight;
    logic            inflight_tag;
    logic [PC_W-1:0] inflight_pc;
    logic            pop;
    logic            push;
    logic            issue;
    logic            pred;
    logic            bht_taken;
    logic [1:0]      occ;
    logic [3:0]      opcode;
    logic [PC_W-1:0] target;

    assign opcode = imem_rdata[INSTR_W-1 -: 4];
    assign target = imem_rdata[4 +: PC_W];

    assign pop  = (count != 2'd0) && !stall;
    assign push = imem_valid && inflight && (inflight_tag == epoch) && !flush;

    // Occupancy after this cycle's pop, counting the word still in flight;
    // a slot freed by a pop can be refilled by an issue in the same cycle.
    assign occ   = count - 2'(pop) + 2'(inflight);
    assign issue = reset_n && !halt && !flush && (occ < 2'd2);

    assign imem_req  = issue;
    assign imem_addr = pc;

    assign valid_IF       = (count != 2'd0);
    assign instruction_IF = valid_IF ? q0.instr : '0;
    assign pc_IF          = valid_IF ? q0.pc : '0;
    assign predict_taken  = valid_IF ? q0.pred : 1'b0;

    // Predict direction of the returning word from its opcode.
    always_comb begin
        pred = 1'b0;
        unique case (1'b1)
            (opcode == JMP_OPCODE): pred = 1'b1;
            (opcode == BR_OPCODE):  pred = bht_taken;
            default:                pred = 1'b0;
        endcase
    end

    assign incoming = {imem_rdata, inflight_pc, pred};

    // Next PC: redirect beats predicted target beats sequential advance.
    always_comb begin
        pc_next = pc;
        if (flush) begin
            pc_next = redirect_pc;
        end else if (push && pred) begin
            pc_next = target;
        end else if (issue) begin
            pc_next = pc + 1'b1;
        end
    end

    // PC, epoch and in-flight request tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc           <= '0;
            epoch        <= 1'b0;
            inflight     <= 1'b0;
            inflight_tag <= 1'b0;
            inflight_pc  <= '0;
        end else begin
            pc           <= pc_next;
            inflight     <= issue;
            inflight_tag <= epoch;
            inflight_pc  <= pc;
            if (flush || (push && pred)) begin
                epoch <= ~epoch;
            end
        end
    end

    // Two-entry fetch queue, head in q0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 2'd0;
            q0    <= '0;
            q1    <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) q0 <= incoming;
                    else               q1 <= incoming;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    q0    <= q1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        q0 <= q1;
                        q1 <= incoming;
                    end else begin
                        q0 <= incoming;
                    end
                end
                default: ;
            endcase
        end
    end

    a_no_push_full: assert property (
        @(posedge clk) disable iff (!reset_n) !(push && count == 2'd2)
    );

`ifdef FETCH_BHT_EN
    logic [1:0]         bht [2**BHT_IDX];
    logic [BHT_IDX-1:0] look_idx;
    logic [BHT_IDX-1:0] upd_idx;
    logic               unused_upc;

    assign look_idx   = inflight_pc[BHT_IDX-1:0];
    assign upd_idx    = update_pc[BHT_IDX-1:0];
    assign bht_taken  = bht[look_idx][1];
    assign unused_upc = ^update_pc[PC_W-1:BHT_IDX];

    // Saturating 2-bit counters trained by resolved branches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2**BHT_IDX; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (update) begin
            if (update_taken) begin
                if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'd1;
            end else begin
                if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'd1;
            end
        end
    end
`else
    logic unused_bht;

    assign bht_taken  = 1'b0;
    assign unused_bht = ^{update, update_pc, update_taken,
                          inflight_pc[BHT_IDX-1:0]};
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table plus corner sequences for fetch_stage.
// Memory model answers one cycle after an accepted request.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic        halt = 1'b0;
    logic        update = 1'b0;
    logic [7:0]  update_pc = 8'h00;
    logic        update_taken = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_valid = 1'b0;
    logic [15:0] instruction_IF;
    logic [7:0]  pc_IF;
    logic        valid_IF;
    logic        predict_taken;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [256];
    logic        pend_v = 1'b0;
    logic [15:0] pend_d = 16'h0000;

    typedef struct {
        logic        s;
        logic        h;
        logic        f;
        logic [7:0]  r;
        logic        rq;
        logic        v;
        logic [7:0]  p;
        logic [15:0] ins;
        logic        pred;
    } vec_t;

    vec_t tv [28];

    fetch_stage dut (
        .clk(clk),
        .reset_n(reset_n),
        .stall(stall),
        .flush(flush),
        .redirect_pc(redirect_pc),
        .halt(halt),
        .update(update),
        .update_pc(update_pc),
        .update_taken(update_taken),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .imem_valid(imem_valid),
        .instruction_IF(instruction_IF),
        .pc_IF(pc_IF),
        .valid_IF(valid_IF),
        .predict_taken(predict_taken)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        pend_v = imem_req;
        pend_d = mem[imem_addr];
    end

    always @(posedge clk) begin
        #1;
        imem_valid = pend_v;
        imem_rdata = pend_d;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic vec_t mk(logic s, logic h, logic f, logic [7:0] r,
                                logic rq, logic v, logic [7:0] p);
        vec_t t;
        t.s    = s;
        t.h    = h;
        t.f    = f;
        t.r    = r;
        t.rq   = rq;
        t.v    = v;
        t.p    = p;
        t.ins  = v ? {8'h00, p} : 16'h0000;
        t.pred = 1'b0;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mem_default();
        for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        update  = 1'b0;
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", 32'(imem_addr), 32'h0);
        chk("rst_valid", 32'(valid_IF), 32'h0);
        chk("rst_instr", 32'(instruction_IF), 32'h0);
        chk("rst_pc", 32'(pc_IF), 32'h0);
        chk("rst_pred", 32'(predict_taken), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic wait_valid(output logic [7:0] p, output logic [15:0] ins,
                              output logic pr, output logic ok);
        ok  = 1'b0;
        p   = 8'h00;
        ins = 16'h0000;
        pr  = 1'b0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            if (valid_IF) begin
                ok  = 1'b1;
                p   = pc_IF;
                ins = instruction_IF;
                pr  = predict_taken;
            end
            @(posedge clk);
            #1;
        end
    endtask

    logic [7:0]  wp;
    logic [15:0] wi;
    logic        wr;
    logic        wok;
    logic [7:0]  exp_pc [8];
    logic        exp_pr [8];
    logic [7:0]  up_pc [6];
    logic        up_tk [6];

    initial begin
        // Straight-line, stall, jump, flush and halt, cycle by cycle.
        tv[0]  = mk(0, 0, 0, 8'h00, 1, 0, 8'h00);
        tv[1]  = mk(0, 0, 0, 8'h00, 1, 0, 8'h00);
        tv[2]  = mk(0, 0, 0, 8'h00, 1, 1, 8'h00);
        tv[3]  = mk(0, 0, 0, 8'h00, 1, 1, 8'h01);
        tv[4]  = mk(0, 0, 0, 8'h00, 1, 1, 8'h02);
        tv[5]  = mk(1, 0, 0, 8'h00, 0, 1, 8'h03);
        tv[6]  = mk(1, 0, 0, 8'h00, 0, 1, 8'h03);
        tv[7]  = mk(1, 0, 0, 8'h00, 0, 1, 8'h03);
        tv[8]  = mk(1, 0, 0, 8'h00, 0, 1, 8'h03);
        tv[9]  = mk(0, 0, 0, 8'h00, 1, 1, 8'h03);
        tv[10] = mk(0, 0, 0, 8'h00, 1, 1, 8'h04);
        tv[11] = mk(0, 0, 0, 8'h00, 1, 1, 8'h05);
        tv[11].ins  = 16'hD0A0;
        tv[11].pred = 1'b1;
        tv[12] = mk(0, 0, 0, 8'h00, 1, 0, 8'h00);
        tv[13] = mk(0, 0, 0, 8'h00, 1, 1, 8'h0A);
        tv[14] = mk(0, 0, 0, 8'h00, 1, 1, 8'h0B);
        tv[15] = mk(1, 0, 0, 8'h00, 0, 1, 8'h0C);
        tv[16] = mk(1, 0, 0, 8'h00, 0, 1, 8'h0C);
        tv[17] = mk(1, 0, 1, 8'h40, 0, 1, 8'h0C);
        tv[18] = mk(0, 0, 0, 8'h00, 1, 0, 8'h00);
        tv[19] = mk(0, 0, 0, 8'h00, 1, 0, 8'h00);
        tv[20] = mk(0, 0, 0, 8'h00, 1, 1, 8'h40);
        tv[21] = mk(0, 0, 0, 8'h00, 1, 1, 8'h41);
        tv[22] = mk(0, 1, 0, 8'h00, 0, 1, 8'h42);
        tv[23] = mk(0, 1, 0, 8'h00, 0, 1, 8'h43);
        tv[24] = mk(0, 1, 0, 8'h00, 0, 0, 8'h00);
        tv[25] = mk(0, 0, 0, 8'h00, 1, 0, 8'h00);
        tv[26] = mk(0, 0, 0, 8'h00, 1, 0, 8'h00);
        tv[27] = mk(0, 0, 0, 8'h00, 1, 1, 8'h44);

        mem_default();
        mem[5] = 16'hD0A0;
        halt = 1'b0;
        do_reset();
        for (int i = 0; i < 28; i++) begin
            stall       = tv[i].s;
            halt        = tv[i].h;
            flush       = tv[i].f;
            redirect_pc = tv[i].r;
            @(negedge clk);
            chk($sformatf("row%0d_req", i), 32'(imem_req), 32'(tv[i].rq));
            chk($sformatf("row%0d_valid", i), 32'(valid_IF), 32'(tv[i].v));
            chk($sformatf("row%0d_instr", i), 32'(instruction_IF),
                32'(tv[i].ins));
            if (tv[i].v) begin
                chk($sformatf("row%0d_pc", i), 32'(pc_IF), 32'(tv[i].p));
                chk($sformatf("row%0d_pred", i), 32'(predict_taken),
                    32'(tv[i].pred));
            end
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        halt  = 1'b0;
        flush = 1'b0;

        // BHT training with saturation, then a fetch run over the branches.
        mem_default();
        mem[1]    = 16'hC300;
        mem[3]    = 16'hC200;
        mem[8'h22] = 16'hC500;
        up_pc = '{8'h03, 8'h03, 8'h22, 8'h22, 8'h22, 8'h22};
        up_tk = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef FETCH_BHT_EN
        exp_pc = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h20, 8'h21, 8'h22, 8'h50};
        exp_pr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
`else
        exp_pc = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        exp_pr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        halt = 1'b1;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            update       = 1'b1;
            update_pc    = up_pc[k];
            update_taken = up_tk[k];
            @(negedge clk);
            if (k == 0) chk("halt_req", 32'(imem_req), 32'h0);
            @(posedge clk);
            #1;
        end
        update = 1'b0;
        halt   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wait_valid(wp, wi, wr, wok);
            chk($sformatf("bht%0d_seen", k), 32'(wok), 32'h1);
            chk($sformatf("bht%0d_pc", k), 32'(wp), 32'(exp_pc[k]));
            chk($sformatf("bht%0d_pred", k), 32'(wr), 32'(exp_pr[k]));
        end

        // PC wrap after a redirect to FE.
        mem_default();
        do_reset();
        flush       = 1'b1;
        redirect_pc = 8'hFE;
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_pc = '{8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int k = 0; k < 3; k++) begin
            wait_valid(wp, wi, wr, wok);
            chk($sformatf("wrap%0d_seen", k), 32'(wok), 32'h1);
            chk($sformatf("wrap%0d_pc", k), 32'(wp), 32'(exp_pc[k]));
            chk($sformatf("wrap%0d_instr", k), 32'(wi),
                32'({8'h00, exp_pc[k]}));
        end

        // Asynchronous reset mid-stream; the late response must be dropped.
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(valid_IF), 32'h0);
        chk("midrst_instr", 32'(instruction_IF), 32'h0);
        chk("midrst_pc", 32'(pc_IF), 32'h0);
        chk("midrst_req", 32'(imem_req), 32'h0);
        chk("midrst_addr", 32'(imem_addr), 32'h0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        wait_valid(wp, wi, wr, wok);
        chk("postrst_seen", 32'(wok), 32'h1);
        chk("postrst_pc", 32'(wp), 32'h0);
        chk("postrst_instr", 32'(wi), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
